// File: rtl/bus_fabric_pkg.sv
// Shared definitions for the bus fabric: FSM states, fault causes and the
// default slave address map (slot i at i<<28, 256 MB windows).
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_MISS  = 3'd1,
    FC_SLV   = 3'd2,
    FC_TMO   = 3'd3,
    FC_PROTO = 3'd4
  } fault_code_t;

  localparam int DEF_N_SLV = 9;

  localparam logic [DEF_N_SLV*32-1:0] DEF_BASE = {
    32'h8000_0000, 32'h7000_0000, 32'h6000_0000,
    32'h5000_0000, 32'h4000_0000, 32'h3000_0000,
    32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [DEF_N_SLV*32-1:0] DEF_MASK = {DEF_N_SLV{32'hF000_0000}};

endpackage

// File: rtl/bus_fabric_decode.sv
// Combinational address decoder: per-slot base/mask match, lowest hit wins.
module bus_fabric_decode #(
  parameter int N_SLV = 9,
  parameter int AW    = 32
) (
  input  logic [AW-1:0]       addr,
  input  logic [N_SLV*AW-1:0] bases,
  input  logic [N_SLV*AW-1:0] masks,
  output logic                hit,
  output logic [3:0]          index
);

  logic [N_SLV-1:0] match;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_match
    assign match[gi] = ((addr & masks[gi*AW +: AW]) == bases[gi*AW +: AW]);
  end

  // Scanning downwards lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit   = 1'b0;
    index = 4'd0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit   = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, N-slave request/response fabric with decode, timeout and a
// sticky fault register that holds until explicitly cleared.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                   N_SLV    = 9,
  parameter int                   AW       = 32,
  parameter int                   DW       = 32,
  parameter int                   ACCW     = 2,
  parameter logic [N_SLV*AW-1:0]  SLV_BASE = DEF_BASE,
  parameter logic [N_SLV*AW-1:0]  SLV_MASK = DEF_MASK,
  parameter int                   TMO_CYC  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       m_addr,
  input  logic                m_w_rb,
  input  logic [ACCW-1:0]     m_acc,
  input  logic [DW-1:0]       m_wdata,
  input  logic                m_req,
  output logic                m_resp,
  output logic [DW-1:0]       m_rdata,
  output logic [N_SLV-1:0]    s_req,
  output logic [AW-1:0]       s_addr,
  output logic                s_w_rb,
  output logic [ACCW-1:0]     s_acc,
  output logic [DW-1:0]       s_wdata,
  input  logic [N_SLV-1:0]    s_resp,
  input  logic [N_SLV*DW-1:0] s_rdata,
  input  logic [N_SLV-1:0]    s_fault,
  output logic                fault,
  output logic [2:0]          fault_code,
  output logic [3:0]          fault_slv,
  output logic [AW-1:0]       fault_addr,
  input  logic                fault_clr
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  state_t      state_reg, state_next;
  logic [SW-1:0] sel_reg, sel_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          fault_reg, fault_next;
  fault_code_t   code_reg, code_next;
  logic [3:0]    fslv_reg, fslv_next;
  logic [AW-1:0] faddr_reg, faddr_next;

  logic          dec_hit;
  logic [3:0]    dec_index;
  logic [SW-1:0] dec_sel;

  bus_fabric_decode #(
    .N_SLV (N_SLV),
    .AW    (AW)
  ) u_decode (
    .addr  (m_addr),
    .bases (SLV_BASE),
    .masks (SLV_MASK),
    .hit   (dec_hit),
    .index (dec_index)
  );

  assign dec_sel = dec_index[SW-1:0];

  assign s_addr     = m_addr;
  assign s_w_rb     = m_w_rb;
  assign s_acc      = m_acc;
  assign s_wdata    = m_wdata;
  assign fault      = fault_reg;
  assign fault_code = code_reg;
  assign fault_slv  = fslv_reg;
  assign fault_addr = faddr_reg;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    fault_next = fault_reg;
    code_next  = code_reg;
    fslv_next  = fslv_reg;
    faddr_next = faddr_reg;
    s_req      = '0;
    m_resp     = 1'b0;
    m_rdata    = '0;
    case (state_reg)
      ST_IDLE: begin
        if (m_req) begin
          if (dec_hit) begin
            s_req[dec_sel] = 1'b1;
            sel_next       = dec_sel;
            addr_next      = m_addr;
            cnt_next       = '0;
            if (s_fault[dec_sel]) begin
              state_next = ST_FAULT;
              fault_next = 1'b1;
              code_next  = FC_SLV;
              fslv_next  = 4'(dec_sel);
              faddr_next = m_addr;
            end else begin
              state_next = ST_BUSY;
            end
          end else begin
            state_next = ST_FAULT;
            fault_next = 1'b1;
            code_next  = FC_MISS;
            fslv_next  = 4'd0;
            faddr_next = m_addr;
          end
        end
      end
      ST_BUSY: begin
        // Priority: slave fault, protocol violation, response, then timeout.
        if (s_fault[sel_reg]) begin
          state_next = ST_FAULT;
          fault_next = 1'b1;
          code_next  = FC_SLV;
          fslv_next  = 4'(sel_reg);
          faddr_next = addr_reg;
        end else if (m_req) begin
          state_next = ST_FAULT;
          fault_next = 1'b1;
          code_next  = FC_PROTO;
          fslv_next  = 4'(sel_reg);
          faddr_next = addr_reg;
        end else if (s_resp[sel_reg]) begin
          m_resp     = 1'b1;
          m_rdata    = s_rdata[32'(sel_reg)*DW +: DW];
          state_next = ST_IDLE;
        end else if (cnt_reg == CW'(TMO_CYC - 1)) begin
          state_next = ST_FAULT;
          fault_next = 1'b1;
          code_next  = FC_TMO;
          fslv_next  = 4'(sel_reg);
          faddr_next = addr_reg;
        end else if (cnt_reg != {CW{1'b1}}) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_next = ST_IDLE;
          fault_next = 1'b0;
          code_next  = FC_NONE;
          fslv_next  = 4'd0;
          faddr_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
      code_reg  <= FC_NONE;
      fslv_reg  <= 4'd0;
      faddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
      code_reg  <= code_next;
      fslv_reg  <= fslv_next;
      faddr_reg <= faddr_next;
    end
  end

endmodule
